dcache_port_arbiter: RTL and testbench

//  Shares one data-cache port (DataCache side of IntfDataCache) between N_REQ requesters.

---
 rtl/dcache_port_arbiter_pkg.sv | 40 ++++
 rtl/dcache_port_arbiter_rr.sv | 38 +++
 rtl/dcache_port_arbiter.sv | 119 +++++++++++
 tb/tb_dcache_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the data-cache port arbiter: FSM state encoding and the
// latched cache request that is replayed onto the cache port.
package dcache_arb_pkg;

  localparam int CACHE_WORD_BYTES = 4;
  localparam int CACHE_ADDR_W     = 32;
  localparam int CACHE_DATA_W     = 8 * CACHE_WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                        write;
    logic                        tag;
    logic [CACHE_ADDR_W-1:0]     address;
    logic [CACHE_WORD_BYTES-1:0] write_select;
    logic [CACHE_DATA_W-1:0]     wr_data;
  } cache_req_t;

  // Reads carry no byte enables or data toward the cache.
  function automatic cache_req_t make_req(
    input logic                        write,
    input logic                        tag,
    input logic [CACHE_ADDR_W-1:0]     address,
    input logic [CACHE_WORD_BYTES-1:0] write_select,
    input logic [CACHE_DATA_W-1:0]     wr_data
  );
    cache_req_t r;
    r.write        = write;
    r.tag          = tag;
    r.address      = address;
    r.write_select = write ? write_select : '0;
    r.wr_data      = write ? wr_data : '0;
    return r;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         request,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N);

  int               slot;
  logic [IDX_W-1:0] idx;
  logic             found;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    slot      = 0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      slot = int'(pointer) + i;
      if (slot >= N) slot = slot - N;
      idx = IDX_W'(slot);
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one data-cache port among N_REQ requesters: round-robin accept, one
// transaction in flight, timeout abort, one-cycle response to the owner.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_write,
  input  logic [N_REQ-1:0]       req_tag,
  input  logic [N_REQ-1:0][31:0] req_address,
  input  logic [N_REQ-1:0][3:0]  req_write_select,
  input  logic [N_REQ-1:0][31:0] req_wr_data,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic                   rsp_hit,
  output logic                   rsp_error,
  output logic [31:0]            rsp_rd_data,
  output logic [31:0]            cache_address,
  output logic                   cache_read,
  output logic                   cache_write,
  output logic                   cache_tag,
  output logic [3:0]             cache_write_select,
  output logic [31:0]            cache_wr_data,
  input  logic                   cache_hit,
  input  logic [31:0]            cache_rd_data,
  input  logic                   cache_done
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_e       state;
  cache_req_t       hold;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] count;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             accept;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .request   (req_valid),
    .pointer   (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? grant : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hold        <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      count       <= '0;
      rsp_hit     <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_rd_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            hold  <= make_req(req_write[grant_idx], req_tag[grant_idx],
                              req_address[grant_idx], req_write_select[grant_idx],
                              req_wr_data[grant_idx]);
            owner <= grant_idx;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          count <= count + 1'b1;
          // A done arriving on the last allowed cycle still wins over the abort.
          if (cache_done) begin
            rsp_hit     <= cache_hit;
            rsp_error   <= 1'b0;
            rsp_rd_data <= cache_rd_data;
            state       <= RESP;
          end else if (count == CNT_LAST) begin
            rsp_hit     <= 1'b0;
            rsp_error   <= 1'b1;
            rsp_rd_data <= '0;
            state       <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
          count  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state flop, so an async reset drops them at once.
  assign cache_read         = (state == BUSY) && !hold.write;
  assign cache_write        = (state == BUSY) &&  hold.write;
  assign cache_address      = hold.address;
  assign cache_tag          = hold.tag;
  assign cache_write_select = hold.write_select;
  assign cache_wr_data      = hold.wr_data;

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: a per-cycle vector table for the
// read/write/contention/stray-done flows, plus hand sequences for timeout and reset.
module tb_dcache_port_arbiter;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0]       req_write = '0;
  logic [1:0]       req_tag = 2'b10;
  logic [1:0][31:0] req_address = {32'h0000_0204, 32'h0000_0100};
  logic [1:0][3:0]  req_write_select = {4'h3, 4'hF};
  logic [1:0][31:0] req_wr_data = {32'h0000_A5A5, 32'hFFFF_FFFF};
  logic [1:0]       rsp_valid;
  logic             rsp_hit, rsp_error;
  logic [31:0]      rsp_rd_data;
  logic [31:0]      cache_address;
  logic             cache_read, cache_write, cache_tag;
  logic [3:0]       cache_write_select;
  logic [31:0]      cache_wr_data;
  logic             cache_hit = 1'b0;
  logic [31:0]      cache_rd_data = '0;
  logic             cache_done = 1'b0;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.N_REQ(2), .TIMEOUT(64)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_tag            (req_tag),
    .req_address        (req_address),
    .req_write_select   (req_write_select),
    .req_wr_data        (req_wr_data),
    .rsp_valid          (rsp_valid),
    .rsp_hit            (rsp_hit),
    .rsp_error          (rsp_error),
    .rsp_rd_data        (rsp_rd_data),
    .cache_address      (cache_address),
    .cache_read         (cache_read),
    .cache_write        (cache_write),
    .cache_tag          (cache_tag),
    .cache_write_select (cache_write_select),
    .cache_wr_data      (cache_wr_data),
    .cache_hit          (cache_hit),
    .cache_rd_data      (cache_rd_data),
    .cache_done         (cache_done)
  );

  typedef struct {
    logic [1:0]  valid, write;
    logic        done, hit;
    logic [31:0] rdata;
    logic [1:0]  e_ready, e_rsp;
    logic        e_rd, e_wr, e_tag;
    logic [31:0] e_addr;
    logic [3:0]  e_ws;
    logic [31:0] e_wd;
    logic        e_hit, e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic        m_hit = 1'b0;
  logic [31:0] m_rdata = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Payload per requester is fixed: req0 reads 0x100 (tag 0), req1 0x204 (tag 1).
  function automatic void row(input logic [1:0] v, input logic [1:0] w, input logic d,
                              input logic h, input logic [31:0] rd,
                              input logic [1:0] e_ready, input logic [1:0] e_rsp,
                              input logic e_rd, input logic e_wr, input int g);
    vec_t r;
    r.valid = v;  r.write = w;  r.done = d;  r.hit = h;  r.rdata = rd;
    r.e_ready = e_ready;  r.e_rsp = e_rsp;  r.e_rd = e_rd;  r.e_wr = e_wr;
    r.e_tag   = (g == 1);
    r.e_addr  = (g == 1) ? 32'h0000_0204 : 32'h0000_0100;
    r.e_ws    = e_wr ? ((g == 1) ? 4'h3 : 4'hF) : 4'h0;
    r.e_wd    = e_wr ? ((g == 1) ? 32'h0000_A5A5 : 32'hFFFF_FFFF) : 32'h0;
    r.e_hit   = m_hit;
    r.e_err   = 1'b0;
    r.e_rdata = m_rdata;
    vecs.push_back(r);
  endfunction

  // One transaction: accept row, lat BUSY rows (done on the last), RESP row.
  function automatic void txn(input int g, input logic [1:0] v, input logic [1:0] w,
                              input int lat, input logic hit, input logic [31:0] rdata,
                              input logic [1:0] bgv, input logic stray);
    logic [1:0] gm;
    logic       wg;
    gm = (g == 1) ? 2'b10 : 2'b01;
    wg = (g == 1) ? w[1] : w[0];
    row(v, w, stray, ~hit, JUNK, gm, 2'b00, 1'b0, 1'b0, g);
    for (int k = 1; k <= lat; k++) begin
      if (k == lat) row(bgv, w, 1'b1, hit, rdata, 2'b00, 2'b00, ~wg, wg, g);
      else          row(bgv, w, 1'b0, ~hit, JUNK, 2'b00, 2'b00, ~wg, wg, g);
    end
    m_hit   = hit;
    m_rdata = rdata;
    row(bgv, w, stray, ~hit, JUNK, 2'b00, gm, 1'b0, 1'b0, g);
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic d,
                       input logic h, input logic [31:0] rd);
    @(posedge clk);
    #1;
    req_valid = v;  req_write = w;
    cache_done = d;  cache_hit = h;  cache_rd_data = rd;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n_strobe;

    // Single read, done 3 cycles after accept.
    txn(0, 2'b01, 2'b00, 3, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0);
    row(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
    // Write from req1, done on the first BUSY cycle; leaves pointer at 0.
    txn(1, 2'b10, 2'b10, 1, 1'b0, 32'h1234_5678, 2'b00, 1'b0);
    row(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
    // Contention: both always valid, four ops each, grants must alternate.
    for (int k = 0; k < 8; k++)
      txn(k % 2, 2'b11, 2'b10, 1, 1'(k % 2), 32'hC0DE_0000 + k, 2'b11, 1'b0);
    // Stray done in IDLE, accept and RESP; done on the first BUSY cycle.
    row(2'b00, 2'b00, 1'b1, 1'b1, JUNK, 2'b00, 2'b00, 1'b0, 1'b0, 0);
    txn(0, 2'b01, 2'b00, 1, 1'b1, 32'h5A5A_0001, 2'b00, 1'b1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'h0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst.cache_read", 32'(cache_read), 32'h0);
    check("rst.cache_write", 32'(cache_write), 32'h0);
    check("rst.cache_address", cache_address, 32'h0);
    check("rst.rsp_error", 32'(rsp_error), 32'h0);
    check("rst.rsp_rd_data", rsp_rd_data, 32'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].write, vecs[i].done, vecs[i].hit, vecs[i].rdata);
      check($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d.rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rsp));
      check($sformatf("v%0d.cache_read", i), 32'(cache_read), 32'(vecs[i].e_rd));
      check($sformatf("v%0d.cache_write", i), 32'(cache_write), 32'(vecs[i].e_wr));
      check($sformatf("v%0d.rsp_hit", i), 32'(rsp_hit), 32'(vecs[i].e_hit));
      check($sformatf("v%0d.rsp_error", i), 32'(rsp_error), 32'(vecs[i].e_err));
      check($sformatf("v%0d.rsp_rd_data", i), rsp_rd_data, vecs[i].e_rdata);
      if (vecs[i].e_rd || vecs[i].e_wr) begin
        check($sformatf("v%0d.cache_address", i), cache_address, vecs[i].e_addr);
        check($sformatf("v%0d.cache_tag", i), 32'(cache_tag), 32'(vecs[i].e_tag));
        check($sformatf("v%0d.cache_write_select", i), 32'(cache_write_select), 32'(vecs[i].e_ws));
        check($sformatf("v%0d.cache_wr_data", i), cache_wr_data, vecs[i].e_wd);
      end
    end

    // Timeout: pointer is at 1, req1 reads and the cache never answers.
    drive(2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
    check("to.accept_ready", 32'(req_ready), 32'h2);
    n_strobe = 0;
    for (int k = 0; k < 80; k++) begin
      drive(2'b00, 2'b00, 1'b0, 1'b1, 32'hFFFF_0000);
      if (cache_read) n_strobe++;
      else break;
    end
    check("to.strobe_cycles", 32'(n_strobe), 32'd64);
    check("to.rsp_valid", 32'(rsp_valid), 32'h2);
    check("to.rsp_error", 32'(rsp_error), 32'h1);
    check("to.rsp_hit", 32'(rsp_hit), 32'h0);
    check("to.rsp_rd_data", rsp_rd_data, 32'h0);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
    check("to.next_ready", 32'(req_ready), 32'h1);
    check("to.error_held", 32'(rsp_error), 32'h1);
    drive(2'b00, 2'b00, 1'b1, 1'b1, 32'h0000_600D);
    check("to.next_read", 32'(cache_read), 32'h1);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    check("to.next_rsp_valid", 32'(rsp_valid), 32'h1);
    check("to.next_rsp_error", 32'(rsp_error), 32'h0);
    check("to.next_rsp_rd_data", rsp_rd_data, 32'h0000_600D);

    // Reset while req1's read is in BUSY (pointer was 1 before reset).
    drive(2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
    check("rb.accept_ready", 32'(req_ready), 32'h2);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    check("rb.busy_read", 32'(cache_read), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rb.read_dropped", 32'(cache_read), 32'h0);
    check("rb.rsp_valid", 32'(rsp_valid), 32'h0);
    check("rb.rsp_hit", 32'(rsp_hit), 32'h0);
    check("rb.rsp_rd_data", rsp_rd_data, 32'h0);
    cache_done = 1'b1;
    cache_hit  = 1'b1;
    @(negedge clk);
    check("rb.in_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    reset_n = 1'b1;
    drive(2'b11, 2'b00, 1'b0, 1'b0, 32'h0);
    check("rb.first_grant", 32'(req_ready), 32'h1);
    check("rb.no_stale_rsp", 32'(rsp_valid), 32'h0);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_0077);
    check("rb.read_addr", cache_address, 32'h0000_0100);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    check("rb.rsp_valid", 32'(rsp_valid), 32'h1);
    check("rb.rsp_rd_data", rsp_rd_data, 32'h0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
